// File: rtl/hog_gradient_if.sv
// Pixel-in / gradient-out stream bundle for the HOG gradient stage.
// Valid-only handshake: pix/sof are sampled only when pix_valid is high, and
// gx/gy/row/col/grad_last mean something only when grad_valid is high. There is
// no ready, so the source is never stalled and the sink must always accept.
interface hog_gradient_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
);
    localparam int G_W = PIX_W + 1;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);

    logic                   pix_valid;
    logic [PIX_W-1:0]       pix;
    logic                   sof;
    logic                   grad_valid;
    logic signed [G_W-1:0]  gx;
    logic signed [G_W-1:0]  gy;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic                   grad_last;
    logic                   frame_err;

    modport master (
        output pix_valid, pix, sof,
        input  grad_valid, gx, gy, row, col, grad_last, frame_err
    );

    modport slave (
        input  pix_valid, pix, sof,
        output grad_valid, gx, gy, row, col, grad_last, frame_err
    );
endinterface

// File: rtl/hog_gradient.sv
// Streaming centred-difference gradient: two line buffers plus a two-column
// window turn raster pixels into (gx, gy) for every interior pixel, one cycle later.
module hog_gradient #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    hog_gradient_if.slave   bus
);
    localparam int G_W = PIX_W + 1;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;

    logic [RW-1:0]    cur_row;
    logic [CW-1:0]    cur_col;
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    // Window: a_mid is P(r-1,c-2); b_* is the column c-1 for rows r-2..r.
    logic [PIX_W-1:0] a_mid, b_top, b_mid, b_bot;

    logic                  accept, restart, emit, at_end;
    logic [RW-1:0]         pr;
    logic [CW-1:0]         pc;
    logic [PIX_W-1:0]      col_top, col_mid;
    logic signed [G_W-1:0] gx_n, gy_n;

    always_comb begin
        restart = bus.pix_valid & bus.sof;
        accept  = bus.pix_valid & ((state == ACTIVE) | bus.sof);
        pr      = restart ? '0 : cur_row;
        pc      = restart ? '0 : cur_col;
        col_top = lb2[pc];
        col_mid = lb1[pc];
        emit    = accept && (pr >= RW'(2)) && (pc >= CW'(2));
        at_end  = (pr == RW'(IMG_H - 1)) && (pc == CW'(IMG_W - 1));
        gx_n    = $signed({1'b0, col_mid}) - $signed({1'b0, a_mid});
        gy_n    = $signed({1'b0, b_bot}) - $signed({1'b0, b_top});
    end

    // Line buffers are never cleared: rows are always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[pc] <= lb1[pc];
            lb1[pc] <= bus.pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cur_row        <= '0;
            cur_col        <= '0;
            a_mid          <= '0;
            b_top          <= '0;
            b_mid          <= '0;
            b_bot          <= '0;
            bus.grad_valid <= 1'b0;
            bus.gx         <= '0;
            bus.gy         <= '0;
            bus.row        <= '0;
            bus.col        <= '0;
            bus.grad_last  <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.grad_valid <= emit;
            bus.grad_last  <= emit && at_end;
            bus.frame_err  <= restart && (state == ACTIVE);
            if (emit) begin
                bus.gx  <= gx_n;
                bus.gy  <= gy_n;
                bus.row <= pr - RW'(1);
                bus.col <= pc - CW'(1);
            end
            if (accept) begin
                a_mid <= b_mid;
                b_top <= col_top;
                b_mid <= col_mid;
                b_bot <= bus.pix;
                if (pc == CW'(IMG_W - 1)) begin
                    cur_col <= '0;
                    cur_row <= at_end ? '0 : pr + RW'(1);
                end else begin
                    cur_col <= pc + CW'(1);
                    cur_row <= pr;
                end
                state <= at_end ? IDLE : ACTIVE;
            end
        end
    end
endmodule

// File: tb/tb_hog_gradient.sv
// Directed-sequence bench with randomized pixels/gaps, checked every cycle
// against an image-array model of the centred-difference gradient.
module tb_hog_gradient;
    localparam int W = 6;
    localparam int H = 5;

    logic clk;
    logic rst;

    hog_gradient_if #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) bus ();

    hog_gradient #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int out_cnt;
    int last_cnt;

    // Model: the frame as an image, the position of the next pixel, held outputs.
    int img [H][W];
    bit m_active;
    int m_r, m_c;
    logic        e_valid, e_last, e_err;
    logic [31:0] e_gx, e_gy, e_row, e_col;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_all();
        chk("grad_valid", 32'(bus.grad_valid), 32'(e_valid));
        chk("frame_err",  32'(bus.frame_err),  32'(e_err));
        chk("grad_last",  32'(bus.grad_last),  32'(e_last));
        chk("gx",  32'($signed(bus.gx)), e_gx);
        chk("gy",  32'($signed(bus.gy)), e_gy);
        chk("row", 32'(bus.row), e_row);
        chk("col", 32'(bus.col), e_col);
        if (bus.grad_valid === 1'b1) out_cnt++;
        if (bus.grad_last === 1'b1) last_cnt++;
    endtask

    task automatic model_clear();
        m_active = 0; m_r = 0; m_c = 0;
        e_valid = 0; e_last = 0; e_err = 0;
        e_gx = 0; e_gy = 0; e_row = 0; e_col = 0;
    endtask

    task automatic step(input bit v, input int p, input bit s);
        @(negedge clk);
        bus.pix_valid = v;
        bus.pix       = 8'(p);
        bus.sof       = s;
        e_valid = 0; e_last = 0; e_err = 0;
        if (v && (m_active || s)) begin
            if (s) begin
                e_err = m_active;
                m_active = 1; m_r = 0; m_c = 0;
            end
            img[m_r][m_c] = p;
            if (m_r >= 2 && m_c >= 2) begin
                e_valid = 1;
                e_gx  = img[m_r-1][m_c] - img[m_r-1][m_c-2];
                e_gy  = img[m_r][m_c-1] - img[m_r-2][m_c-1];
                e_row = m_r - 1;
                e_col = m_c - 1;
                e_last = (m_r == H-1) && (m_c == W-1);
            end
            if (m_c == W-1) begin
                m_c = 0;
                if (m_r == H-1) begin
                    m_r = 0; m_active = 0;
                end else m_r++;
            end else m_c++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pix_for(input int mode, input int r, input int c);
        case (mode)
            0: return 10 * c;
            1: return 7 * r;
            2: return (r == 2 && c == 2) ? 255 : 0;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    // Sends a frame up to (not including) pixel (stop_r, stop_c); stop_r < 0 sends it all.
    task automatic send_frame(input int mode, input bit gaps, input int stop_r, input int stop_c);
        out_cnt = 0;
        last_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                while (gaps && $urandom_range(1) == 0)
                    step(0, int'($urandom_range(255)), 1'($urandom_range(1)));
                step(1, pix_for(mode, r, c), (r == 0 && c == 0));
            end
        end
    endtask

    task automatic frame_counts();
        chk("out_count",  32'(out_cnt),  32'((W-2)*(H-2)));
        chk("last_count", 32'(last_cnt), 32'(1));
    endtask

    initial begin
        rst = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix = '0;
        bus.sof = 1'b0;
        model_clear();
        do_reset();

        out_cnt = 0;
        for (int i = 0; i < 10; i++) step(1, int'($urandom_range(255)), 1'b0);
        chk("no_sof_outputs", 32'(out_cnt), 32'(0));

        send_frame(0, 1'b0, -1, 0);
        frame_counts();
        step(0, 0, 1'b0);

        send_frame(1, 1'b1, -1, 0);
        frame_counts();

        send_frame(2, 1'b0, -1, 0);
        frame_counts();
        step(0, 0, 1'b0);

        send_frame(3, 1'b0, 3, 1);
        send_frame(3, 1'b0, -1, 0);
        frame_counts();

        send_frame(3, 1'b1, 2, 5);
        do_reset();
        send_frame(3, 1'b0, -1, 0);
        frame_counts();

        send_frame(3, 1'b0, -1, 0);
        send_frame(3, 1'b1, -1, 0);
        frame_counts();
        for (int i = 0; i < 4; i++) step(0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hog_gradient.md
Name: hog_gradient

Overview:
Streaming centred-difference gradient stage of the HOG pipeline. Accepts 8-bit grey pixels in raster order and produces signed horizontal/vertical gradients (gx, gy) for every interior pixel. Output feeds the divider stage directly (a = gy, b = gx, both 9-bit signed) and the downstream magnitude/binning logic. It sits between the pixel source and the divider, holds two line buffers and a 3x3 window, and does not back-pressure its source.

Parameters:
IMG_W  640  frame width in pixels (>= 3)
IMG_H  480  frame height in pixels (>= 3)
PIX_W  8    input pixel width, unsigned
(localparam G_W = PIX_W + 1: gradient width, signed)
(localparam CW = clog2(IMG_W), RW = clog2(IMG_H))

Ports:
clk         in   1     system clock, all logic rising-edge
rst         in   1     asynchronous, active-high reset
pix_valid   in   1     pixel qualifier; pix/sof sampled only when high
pix         in   PIX_W unsigned pixel
sof         in   1     with pix_valid: this pixel is (row 0, col 0)
grad_valid  out  1     gx/gy/row/col valid this cycle
gx          out  G_W   signed, P(r,c+1) - P(r,c-1)
gy          out  G_W   signed, P(r+1,c) - P(r-1,c)
row         out  RW    centre pixel row r
col         out  CW    centre pixel column c
grad_last   out  1     high with the output for centre (IMG_H-2, IMG_W-2)
frame_err   out  1     one-cycle pulse: sof received while a frame was in progress

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0. Line buffer contents need not be cleared.
- States: IDLE -> ACTIVE on pix_valid & sof. ACTIVE -> IDLE after accepting pixel (IMG_H-1, IMG_W-1). In IDLE, pixels without sof are dropped. No outputs are produced in IDLE.
- Accepted pixel = pix_valid high in ACTIVE, or the sof pixel. Each accepted pixel advances col; col wraps IMG_W-1 -> 0 and increments row.
- pix_valid low: no state change, window/line buffers hold, grad_valid 0. Gaps of any length are allowed anywhere in a frame.
- Output rule: accepting pixel (r,c) with r >= 2 and c >= 2 produces exactly one output for centre (r-1, c-1). It appears with grad_valid = 1 on the next rising edge (latency 1 cycle, independent of gaps).
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) produce no output. Outputs per frame = (IMG_W-2)*(IMG_H-2), in raster order of the centre pixel.
- Arithmetic: operands are zero-extended to G_W bits and subtracted in G_W-bit signed arithmetic. The range is -(2^PIX_W - 1)..+(2^PIX_W - 1), so the result never overflows and is never saturated.
- No window data crosses a row boundary or a frame boundary. At col 0 and col 1 of each row the window is refilled before any output is produced.
- Outputs are registered. gx/gy/row/col hold their last value while grad_valid = 0.
- sof in ACTIVE (mid-frame): pulse frame_err for 1 cycle, abandon the frame, and treat this pixel as (0,0). No further outputs come from the abandoned frame. An output already scheduled from the previous accepted pixel still emits on its cycle.
- sof on pixel (0,0) immediately after the final pixel of a frame (state IDLE) is not an error.
- grad_last asserts only together with grad_valid for centre (IMG_H-2, IMG_W-2).

Test Plan:
- IMG_W=6, IMG_H=5, horizontal ramp pix=10*c, continuous valid -> 12 outputs, all gx=+20, gy=0. Row/col run (1,1)..(3,4). grad_last only on (3,4). Each output 1 cycle after pixel (r+1,c+1).
- Vertical ramp pix=7*r, random pix_valid gaps (~50%) -> 12 outputs, gx=0, gy=+14. Raster order and count unchanged; no output during gaps.
- Single bright pixel 255 at (2,2), rest 0 -> centre (2,1) gx=+255; (2,3) gx=-255; (1,2) gy=+255; (3,2) gy=-255; all others 0. Checks full signed range without wrap.
- sof re-asserted at pixel (3,1) of a frame -> frame_err pulse 1 cycle, no further outputs from the old frame. The new frame yields 12 correct outputs.
- Pixels presented without sof after reset -> no outputs, frame_err 0. Then a sof frame -> normal 12 outputs.
- rst asserted mid-frame (at pixel (2,4)) -> all outputs 0 immediately, state IDLE. A following full frame gives correct results with no stale data from before the reset.
